// File: rtl/debounce_sync.sv
// debounce_sync: input conditioning stage placed in front of the d_ff cell.
// A raw asynchronous 1-bit input is brought into CLK by a SYNC_STAGES-deep
// synchroniser. A two-state STABLE/VERIFY FSM then filters it. DOUT only moves
// after STABLE_CYCLES consecutive EN-qualified samples of the new level.
// RISE/FALL are one-cycle pulses, aligned with the cycle in which DOUT changes.
//
// Optional feature, enabled by defining DEBOUNCE_STATS_EN:
//   - Adds the 8-bit BOUNCE_CNT output.
//   - BOUNCE_CNT is a saturating count of VERIFY aborts.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       DIN,
  input  logic       EN,
  output logic       DOUT,
  output logic       RISE,
  output logic       FALL,
  output logic       BUSY
`ifdef DEBOUNCE_STATS_EN
  ,
  output logic [7:0] BOUNCE_CNT
`endif
);

  // Elaboration-time guard on the parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES must be in 2..2^CNT_W-1");
  end

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_VERIFY = 1'b1
  } state_e;

  // Final count value: the sample that lands here commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchroniser chain. It shifts every cycle and ignores EN, so the metastability
  // settling time does not depend on the sample tick.
  // NOTE: sequential blocks use non-blocking (<=) assignments. Every flop then
  // samples the value from before the edge. This is what makes the chain a real
  // multi-stage shift and not a single wire.
  // NOTE: the reset is in the sensitivity list. The flops therefore clear as soon
  // as CLR_N falls, with no wait for a CLK edge.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], DIN};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic. A commit loads the pulse for one cycle only, because
  // rise_d/fall_d fall back to 0 by default.
  // NOTE: every output of this block gets a default before the case statement.
  // Without those defaults, a path that leaves a signal unassigned would infer a
  // latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      ST_STABLE: begin
        if (EN && (s != dout_q)) begin
          state_d = ST_VERIFY;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_VERIFY: begin
        if (s == dout_q) begin
          // The input returned before the count completed. Drop the attempt
          // without any output change.
          state_d = ST_STABLE;
        end else if (EN) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE;
            dout_d  = s;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // With no tick, the count is frozen. There is no timeout, however long
          // EN stays low.
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  assign DOUT = dout_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign BUSY = (state_q == ST_VERIFY);

`ifdef DEBOUNCE_STATS_EN
  logic       abort;
  logic [7:0] bounce_q;

  // An abort is any VERIFY cycle in which the synchronised input matches DOUT
  // again.
  assign abort = (state_q == ST_VERIFY) && (s == dout_q);

  // Saturating abort counter. Commits leave it untouched.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      bounce_q <= 8'd0;
    end else if (abort && (bounce_q != 8'hFF)) begin
      bounce_q <= bounce_q + 8'd1;
    end
  end

  assign BOUNCE_CNT = bounce_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: scoreboard bench for debounce_sync at default parameters.
// Each driven cycle pushes its expected {DOUT,RISE,FALL,BUSY}. The entry is
// popped and compared 1 ns after the clock edge. Expected values come from the
// edge-count timing of the debouncer: the synchroniser depth, then STABLE_CYCLES
// EN-qualified samples. With DEBOUNCE_STATS_EN defined, BOUNCE_CNT is checked too.
module tb_debounce_sync;

  localparam int SS = 2;  // SYNC_STAGES
  localparam int SC = 4;  // STABLE_CYCLES

  logic CLK = 1'b0;
  logic CLR_N;
  logic DIN;
  logic EN;
  logic DOUT, RISE, FALL, BUSY;
`ifdef DEBOUNCE_STATS_EN
  logic [7:0] BOUNCE_CNT;
`endif

  debounce_sync #(
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .CNT_W        (8),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .DIN  (DIN),
    .EN   (EN),
    .DOUT (DOUT),
    .RISE (RISE),
    .FALL (FALL),
    .BUSY (BUSY)
`ifdef DEBOUNCE_STATS_EN
    ,
    .BOUNCE_CNT(BOUNCE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [3:0] exp;  // {DOUT, RISE, FALL, BUSY}
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_vec = 0;
  int        n_bad = 0;
  logic      lvl;       // bench-side model of the debounced level
  int        bounce_m;  // bench-side model of the abort counter

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, record the expectation, then pop and compare
  // it after the edge.
  task automatic tick(input logic din, input logic en, input logic [3:0] exp, input string tag);
    sb_entry_t e;
    DIN = din;
    EN  = en;
    sb.push_back('{tag, exp});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check(e.tag, {4'b0, DOUT, RISE, FALL, BUSY}, {4'b0, e.exp});
  endtask

  // Hold DIN at ~lvl. EN is high on every en_period-th edge. The commit happens
  // at the SC-th EN-qualified edge after the synchroniser delay.
  task automatic transition(input int en_period, input string tag);
    logic nw;
    int   q;
    bit   done;
    logic en;
    nw   = ~lvl;
    q    = 0;
    done = 1'b0;
    for (int n = 1; n <= SS + SC * en_period + 3; n++) begin
      en = ((n % en_period) == 0);
      if (!done && n >= SS + 1 && en) q++;
      if (!done && q == SC) begin
        tick(nw, en, {nw, nw, ~nw, 1'b0}, tag);
        done = 1'b1;
      end else if (done) begin
        tick(nw, en, {nw, 3'b000}, tag);
      end else begin
        tick(nw, en, {lvl, 2'b00, (q >= 1)}, tag);
      end
    end
    lvl = nw;
  endtask

  // Glitch of len cycles with EN=1. Requires len < SC. BUSY is high on the edges
  // where s still differs from DOUT. The abort edge drops BUSY with no output
  // change.
  task automatic glitch(input int len, input string tag);
    for (int n = 1; n <= SS + len + 3; n++) begin
      tick((n <= len) ? ~lvl : lvl, 1'b1,
           {lvl, 2'b00, (n >= SS + 1 && n <= SS + len)}, tag);
    end
    if (bounce_m < 255) bounce_m++;
`ifdef DEBOUNCE_STATS_EN
    check({tag, "_bcnt"}, BOUNCE_CNT, 8'(bounce_m));
`endif
  endtask

  initial begin
    // Reset asserted with DIN high: all outputs held at the reset values.
    CLR_N    = 1'b0;
    DIN      = 1'b1;
    EN       = 1'b1;
    lvl      = 1'b0;
    bounce_m = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_hold", {4'b0, DOUT, RISE, FALL, BUSY}, 8'h00);
`ifdef DEBOUNCE_STATS_EN
    check("rst_bcnt", BOUNCE_CNT, 8'd0);
`endif
    DIN = 1'b0;
    #3 CLR_N = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 4'b0000, "rst_release");

    // Sub-threshold glitches from DOUT=0: the shortest, the spec case and the longest.
    glitch(2, "glitch_hi2");
    glitch(1, "glitch_hi1");
    glitch(SC - 1, "glitch_hi3");

    // Clean rise with EN=1: RISE coincides with DOUT=1 on edge SS+SC.
    transition(1, "clean_rise");

    // Glitch low from DOUT=1.
    glitch(2, "glitch_lo2");

    // EN on every 3rd edge: BUSY stays high through the EN=0 gaps.
    transition(3, "en_gated_fall");

    // Reset mid-VERIFY: outputs clear before the next CLK edge, and no RISE follows.
    for (int n = 1; n <= SS + 2; n++) tick(1'b1, 1'b1, {3'b000, (n >= SS + 1)}, "pre_rst_verify");
    #2;
    DIN   = 1'b0;
    CLR_N = 1'b0;
    #1;
    check("rst_async", {4'b0, DOUT, RISE, FALL, BUSY}, 8'h00);
    bounce_m = 0;
`ifdef DEBOUNCE_STATS_EN
    check("rst_async_bcnt", BOUNCE_CNT, 8'd0);
`endif
    #2 CLR_N = 1'b1;
    lvl = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 4'b0000, "post_rst");

    // Many sub-threshold glitches: DOUT never moves, the abort count saturates.
    for (int i = 0; i < 300; i++) glitch(1 + (i % (SC - 1)), "sat_glitch");
`ifdef DEBOUNCE_STATS_EN
    check("sat_bcnt", BOUNCE_CNT, 8'd255);
`endif

    // A real change still goes through after the glitch storm.
    transition(1, "final_rise");
    transition(2, "final_fall");

    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
